// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter driven by an external baud generator tick.
// Frames a DATA_BITS-wide word as start bit, LSB-first data, optional even
// parity and STOP_BITS stop bits. The generator is enabled only while a frame
// is in flight, so each frame starts from a freshly cleared generator count.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP        = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_d, baud_en_d, tx_busy_d, tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic; everything holds between baud ticks
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx;
    baud_en_d  = baud_en;
    tx_busy_d  = tx_busy;
    tx_done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d   = S_START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          baud_en_d = 1'b1;
          tx_busy_d = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d    = S_PARITY;
            tx_d       = parity_q;
`else
            state_d    = S_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d   = S_IDLE;
            baud_en_d = 1'b0;
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx         <= 1'b1;
      baud_en    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx         <= tx_d;
      baud_en    <= baud_en_d;
      tx_busy    <= tx_busy_d;
      tx_done    <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a baud generator model
// (CLOCK_RATE=16, BAUD_RATE=4, bit period 5 clocks), a frame-level reference
// model, a line receiver and literal expectations for each scenario.
module tb_uart_tx;

  localparam int DB         = 8;
  localparam int SB         = 1;
  localparam int CLOCK_RATE = 16;
  localparam int BAUD_RATE  = 4;
  localparam int DIV        = CLOCK_RATE / BAUD_RATE;
  localparam int P          = DIV + 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB                = 1;
  localparam int A5_LAT            = 55;
  localparam logic [15:0] A5_BITS  = 16'h054A;
`else
  localparam int PB                = 0;
  localparam int A5_LAT            = 50;
  localparam logic [15:0] A5_BITS  = 16'h034A;
`endif
  localparam int FL = 1 + DB + PB + SB;
  localparam int LP = FL * P;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_start;
  logic [DB-1:0] tx_data;
  logic          baud_tick = 1'b0;
  logic          baud_en, tx, tx_busy, tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  uart_tx #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .baud_tick(baud_tick),
    .baud_en  (baud_en),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  // Cycle counter: value k at a negedge means k rising edges have occurred
  always @(posedge clk) cyc++;

  // Baud generator: counter cleared while disabled, one-cycle tick every P clocks
  int gen_cnt = 0;
  always @(posedge clk) begin
    if (baud_en !== 1'b1) begin
      gen_cnt   <= 0;
      baud_tick <= 1'b0;
    end else begin
      gen_cnt   <= (gen_cnt == DIV) ? 0 : gen_cnt + 1;
      baud_tick <= (gen_cnt == DIV - 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: m_d counts clocks since the accepting edge
  bit          m_active = 1'b0;
  int          m_d      = 0;
  logic [DB-1:0] m_data = '0;
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_active = 1'b0;
    end else if (tx_start === 1'b1 && !(m_active && m_d < LP)) begin
      m_active = 1'b1;
      m_d      = 0;
      m_data   = tx_data;
    end else if (m_active) begin
      m_d++;
      if (m_d > LP) m_active = 1'b0;
    end
  end

  function automatic logic exp_bit(input int i);
    if (i == 0) return 1'b0;
    if (i <= DB) return m_data[i-1];
    if (PB == 1 && i == DB + 1) return ^m_data;
    return 1'b1;
  endfunction

  // Per-cycle compare of all outputs against the reference
  bit   chk_en = 1'b0;
  logic e_tx, e_en, e_busy, e_done;
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_active && m_d < LP) begin
        e_tx = exp_bit(m_d / P); e_en = 1'b1; e_busy = 1'b1; e_done = 1'b0;
      end else if (m_active && m_d == LP) begin
        e_tx = 1'b1; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b1;
      end else begin
        e_tx = 1'b1; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end
      check("cyc_tx", tx, e_tx);
      check("cyc_baud_en", baud_en, e_en);
      check("cyc_tx_busy", tx_busy, e_busy);
      check("cyc_tx_done", tx_done, e_done);
    end
  end

  // Line receiver and event monitor; samples each bit mid-period
  logic          prev_tx   = 1'b1;
  bit            rx_on     = 1'b0;
  int            rx_fall   = 0;
  int            rx_i      = 0;
  logic [15:0]   rx_bits   = '0;
  logic [15:0]   last_bits = '0;
  logic [DB-1:0] rx_q[$];
  int fall_cyc = -1, done_cyc = -1, done_cnt = 0, fall_cnt = 0, en_low = 0;
  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (baud_en === 1'b0) en_low++;
    if (rst === 1'b1) begin
      rx_on = 1'b0;
    end else if (!rx_on && prev_tx === 1'b1 && tx === 1'b0) begin
      rx_on    = 1'b1;
      rx_fall  = cyc;
      rx_bits  = '0;
      fall_cyc = cyc;
      fall_cnt++;
    end
    if (rx_on && ((cyc - rx_fall) % P == 2)) begin
      rx_i          = (cyc - rx_fall) / P;
      rx_bits[rx_i] = tx;
      if (rx_i == FL - 1) begin
        rx_on     = 1'b0;
        last_bits = rx_bits;
        rx_q.push_back(rx_bits[DB:1]);
      end
    end
    prev_tx = tx;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [DB-1:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic check_rx(input string name, input logic [DB-1:0] exp);
    check({name, "_avail"}, rx_q.size() != 0, 1);
    if (rx_q.size() != 0) check(name, rx_q.pop_front(), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, n, d1cyc, f;
    // Reset with a competing start request: reset must win
    rst      = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    step();
    chk_en = 1'b1;
    step();
    step();
    rst      = 1'b0;
    tx_start = 1'b0;
    repeat (20) step();
    check("idle_tx", tx, 1'b1);
    check("idle_baud_en", baud_en, 1'b0);
    check("idle_falls", fall_cnt, 0);
    check("idle_done", done_cnt, 0);

    // Single frame 0xA5
    d0 = done_cnt;
    send(8'hA5);
    wait_done(d0, 200, "a5");
    check("a5_bits", last_bits, A5_BITS);
    check("a5_latency", done_cyc - fall_cyc, A5_LAT);
    check_rx("a5_byte", 8'hA5);
    repeat (3) step();

    // 0x07: three ones, so the bit after the data is 1 in either build
    d0 = done_cnt;
    send(8'h07);
    wait_done(d0, 200, "p07");
    check("p07_bit9", last_bits[DB+1], 1'b1);
    check("p07_latency", done_cyc - fall_cyc, A5_LAT);
    check_rx("p07_byte", 8'h07);
    repeat (3) step();

    // Start strobe while busy is ignored
    d0 = done_cnt;
    send(8'h3C);
    repeat (11) step();
    send(8'hFF);
    wait_done(d0, 200, "busy");
    repeat (80) step();
    check("busy_done_count", done_cnt - d0, 1);
    check_rx("busy_byte", 8'h3C);
    check("busy_no_extra", rx_q.size(), 0);

    // Back-to-back frames: restart on the tx_done cycle
    d0 = done_cnt;
    send(8'h55);
    e0 = en_low;
    n  = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      e0 = en_low;
      step();
      n++;
    end
    check("b2b_first_done", tx_done, 1'b1);
    d1cyc    = cyc;
    tx_data  = 8'h81;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (3) step();
    check("b2b_gap", fall_cyc - d1cyc, 1);
    check("b2b_en_low", en_low - e0, 1);
    wait_done(d0 + 1, 200, "b2b");
    check_rx("b2b_byte0", 8'h55);
    check_rx("b2b_byte1", 8'h81);
    repeat (3) step();

    // Reset during data bit 3 of 0xF0, then a clean 0x0F frame
    d0 = done_cnt;
    send(8'hF0);
    f = fall_cyc;
    n = 0;
    while (cyc < f + 21 && n < 100) begin
      step();
      n++;
    end
    check("rst_mid_tx_before", tx, 1'b0);
    rst = 1'b1;
    step();
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_baud_en", baud_en, 1'b0);
    rst = 1'b0;
    repeat (60) step();
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_byte", rx_q.size(), 0);
    send(8'h0F);
    wait_done(d0, 200, "after_rst");
    check_rx("after_rst_byte", 8'h0F);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter that sits directly downstream of the baud generator in the UART datapath. It accepts a parallel byte through a start strobe, frames it as start bit, LSB-first data bits, an optional parity bit and stop bit(s), and drives the serial line. It enables the baud generator only while a frame is in flight. Each bit advances on the generator's one-cycle `enable_clk` tick.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..8.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tx_start` input 1: one-cycle request; honoured only when `tx_busy` is 0.
- `tx_data` input `DATA_BITS`: byte to send; sampled on the cycle `tx_start` is accepted.
- `baud_tick` input 1: bit-period tick, connected to the generator's `enable_clk`.
- `baud_en` output 1: generator enable, connected to the generator's `baud_en`; high only during a frame.
- `tx` output 1: serial line; idles high.
- `tx_busy` output 1: high from the cycle after acceptance through the end of the last stop bit.
- `tx_done` output 1: one-cycle pulse when the frame completes.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro defined), STOP.
- IDLE: `tx`=1, `baud_en`=0, `tx_busy`=0.
  - `tx_start`=1 latches `tx_data` into a shift register, clears the bit counter and enters START.
  - On the same edge, `tx`<=0, `baud_en`<=1 and `tx_busy`<=1.
- START, on `baud_tick`:
  - Go to DATA.
  - `tx`<=shift[0].
- DATA, on `baud_tick`:
  - If bit_cnt == `DATA_BITS`-1, go to PARITY (or STOP without the macro).
  - Otherwise shift right, increment bit_cnt and set `tx`<=next bit.
- PARITY, on `baud_tick`: go to STOP and set `tx`<=1.
- STOP, on `baud_tick`:
  - If stop_cnt == `STOP_BITS`-1, go to IDLE.
  - On that edge, `baud_en`<=0, `tx_busy`<=0 and `tx_done`<=1.
  - Otherwise increment stop_cnt.
- Between ticks, all state and outputs hold.
- `tx_start` while `tx_busy`=1 is ignored entirely: no queuing and no corruption of the in-flight data.
- A `baud_tick` seen in IDLE is ignored.
- Deasserting `baud_en` between frames restarts the generator's counter. Every bit therefore lasts exactly one generator period, including the start bit.
- Counter widths: bit_cnt is $clog2(`DATA_BITS`) bits; stop_cnt is 1 bit. Neither counter wraps within a frame.

## Timing
- Reset values: `tx`=1, `baud_en`=0, `tx_busy`=0, `tx_done`=0, state=IDLE, counters=0.
- Reset mid-frame: on the next edge, `tx` returns to 1 and `baud_en` to 0. No `tx_done` pulse is produced.
- Latency: `tx` falls on the first edge after `tx_start` is sampled high.
- Bit period: every bit, start bit included, is held for exactly the tick interval P. With the generator, P = CLOCK_RATE/BAUD_RATE + 1 clocks.
- Frame length: (1 + `DATA_BITS` + parity + `STOP_BITS`) × P clocks of low-start framing.
- `tx_done` is high for exactly one cycle, on the same cycle `tx_busy` drops.
- Back-to-back frames:
  - A `tx_start` in the cycle where `tx_done`=1 is accepted.
  - The next start bit begins one cycle after that.
  - `baud_en` drops for that single cycle, which restarts the generator.
- If `rst` and `tx_start` are both high, `rst` wins.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state inserts one bit after the data bits.
  - The bit is even parity, i.e. the XOR of the `DATA_BITS` bits latched at acceptance.
  - Frame length grows by P.
- Not defined: the PARITY state and its logic are absent, and DATA goes directly to STOP.

## Test plan
- Reset then idle, real generator with CLOCK_RATE=16, BAUD_RATE=4 (P=5):
  - Hold `rst`=1 for 3 cycles.
  - Required: `tx`=1 and `baud_en`=`tx_busy`=`tx_done`=0 throughout and for 20 idle cycles after release.
- Single frame, `tx_data`=0xA5, no parity, `STOP_BITS`=1, P=5:
  - Required line sequence, 5 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_done` pulses once, 50 cycles after `tx` falls.
- Parity build, `tx_data`=0x07:
  - Parity bit=1 (three ones).
  - Frame is 11 bits = 55 cycles.
- Start ignored while busy:
  - Send 0x3C, then pulse `tx_start` with 0xFF at cycle 12.
  - Required: the serialized bits are still 0x3C, and exactly one `tx_done`.
- Back-to-back: send 0x55, then assert `tx_start` with 0x81 on the `tx_done` cycle.
  - Required: the second start bit falls one cycle later.
  - Two correct frames.
  - `baud_en` is low for exactly one cycle between them.
- Reset mid-frame:
  - Assert `rst` during data bit 3 of 0xF0.
  - Required: `tx`=1 and `baud_en`=0 on the next edge, no `tx_done`.
  - A following 0x0F frame is correct.
